// File: rtl/cam_dvp_capture_module_if.sv
// DVP camera bus, frame-buffer write port and status for cam_dvp_capture_module.
// The optional statistics signals exist only when CAPTURE_STATS_EN is defined.
interface cam_dvp_capture_module_if;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        capture_en;
  logic        fifo_full;
  logic        err_clr;
  logic [15:0] pix_data;
  logic        pix_wr;
  logic        frame_start;
  logic        frame_done;
  logic        err_ovf;
  logic        err_odd;
  logic        err_geom;
`ifdef CAPTURE_STATS_EN
  logic [15:0] frame_cnt;
  logic [11:0] last_line_len;
  logic [10:0] last_frame_lines;

  modport master (
    output cam_vsync, cam_href, cam_data, capture_en, fifo_full, err_clr,
    input  pix_data, pix_wr, frame_start, frame_done, err_ovf, err_odd, err_geom,
    input  frame_cnt, last_line_len, last_frame_lines
  );
  modport slave (
    input  cam_vsync, cam_href, cam_data, capture_en, fifo_full, err_clr,
    output pix_data, pix_wr, frame_start, frame_done, err_ovf, err_odd, err_geom,
    output frame_cnt, last_line_len, last_frame_lines
  );
`else
  modport master (
    output cam_vsync, cam_href, cam_data, capture_en, fifo_full, err_clr,
    input  pix_data, pix_wr, frame_start, frame_done, err_ovf, err_odd, err_geom
  );
  modport slave (
    input  cam_vsync, cam_href, cam_data, capture_en, fifo_full, err_clr,
    output pix_data, pix_wr, frame_start, frame_done, err_ovf, err_odd, err_geom
  );
`endif
endinterface

// File: rtl/cam_dvp_capture_module.sv
// DVP camera capture: packs byte pairs into RGB565 words for the frame-buffer FIFO.
// Optional macro CAPTURE_STATS_EN adds frame/line statistics outputs.
module cam_dvp_capture_module #(
  parameter int unsigned SKIP_FRAMES = 10,
  parameter int unsigned H_PIXELS    = 1024,
  parameter int unsigned V_LINES     = 720
) (
  input logic                      CLK,
  input logic                      RSTn,
  cam_dvp_capture_module_if.slave  bus
);

  localparam int unsigned LINE_W  = 12;
  localparam int unsigned FRAME_W = 11;
  localparam int unsigned SKIP_W  = $clog2(SKIP_FRAMES + 2);

  localparam logic [1:0] ST_SKIP   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               vsync_s1_q, vsync_s2_q, href_s1_q, href_s2_q;
  logic [7:0]         data_s1_q;
  logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic               phase_q, phase_d;
  logic [7:0]         hi_q, hi_d;
  logic [LINE_W-1:0]  line_len_q, line_len_d;
  logic [FRAME_W-1:0] frame_lines_q, frame_lines_d;
  logic [15:0]        pix_data_q, pix_data_d;
  logic               pix_wr_q, pix_wr_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_done_q, frame_done_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_odd_q, err_odd_d;
  logic               err_geom_q, err_geom_d;
  logic               ovf_set, odd_set, geom_set;
  logic               vs_rise, vs_fall, href_rise, href_fall;
`ifdef CAPTURE_STATS_EN
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic [LINE_W-1:0]  last_line_len_q, last_line_len_d;
  logic [FRAME_W-1:0] last_frame_lines_q, last_frame_lines_d;
`endif

  assign vs_rise   =  vsync_s1_q & ~vsync_s2_q;
  assign vs_fall   = ~vsync_s1_q &  vsync_s2_q;
  assign href_rise =  href_s1_q  & ~href_s2_q;
  assign href_fall = ~href_s1_q  &  href_s2_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= ST_SKIP;
      vsync_s1_q    <= 1'b0;
      vsync_s2_q    <= 1'b0;
      href_s1_q     <= 1'b0;
      href_s2_q     <= 1'b0;
      data_s1_q     <= '0;
      skip_cnt_q    <= '0;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      pix_data_q    <= '0;
      pix_wr_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_ovf_q     <= 1'b0;
      err_odd_q     <= 1'b0;
      err_geom_q    <= 1'b0;
`ifdef CAPTURE_STATS_EN
      frame_cnt_q        <= '0;
      last_line_len_q    <= '0;
      last_frame_lines_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      vsync_s1_q    <= bus.cam_vsync;
      vsync_s2_q    <= vsync_s1_q;
      href_s1_q     <= bus.cam_href;
      href_s2_q     <= href_s1_q;
      data_s1_q     <= bus.cam_data;
      skip_cnt_q    <= skip_cnt_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      pix_data_q    <= pix_data_d;
      pix_wr_q      <= pix_wr_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      err_ovf_q     <= err_ovf_d;
      err_odd_q     <= err_odd_d;
      err_geom_q    <= err_geom_d;
`ifdef CAPTURE_STATS_EN
      frame_cnt_q        <= frame_cnt_d;
      last_line_len_q    <= last_line_len_d;
      last_frame_lines_q <= last_frame_lines_d;
`endif
    end
  end

  // Frame sequencing, byte packing, geometry checks and sticky error flags.
  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    pix_data_d    = pix_data_q;
    pix_wr_d      = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    ovf_set       = 1'b0;
    odd_set       = 1'b0;
    geom_set      = 1'b0;
`ifdef CAPTURE_STATS_EN
    frame_cnt_d        = frame_cnt_q;
    last_line_len_d    = last_line_len_q;
    last_frame_lines_d = last_frame_lines_q;
`endif

    case (state_q)
      ST_SKIP: begin
        if (skip_cnt_q == SKIP_W'(SKIP_FRAMES)) begin
          state_d = ST_WAIT;
        end else if (vs_rise) begin
          skip_cnt_d = skip_cnt_q + SKIP_W'(1);
        end
      end
      ST_WAIT: begin
        if (vs_fall && bus.capture_en) begin
          state_d       = ST_ACTIVE;
          frame_start_d = 1'b1;
          frame_lines_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (href_s1_q) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            hi_d = data_s1_q;
          end else begin
            // A word blocked by a full FIFO is lost but still occupies a line slot.
            line_len_d = line_len_q + LINE_W'(1);
            if (bus.fifo_full) begin
              ovf_set = 1'b1;
            end else begin
              pix_wr_d   = 1'b1;
              pix_data_d = {hi_q, data_s1_q};
            end
          end
        end
        if (href_rise) begin
          line_len_d = '0;
        end
        if (href_fall) begin
          odd_set       = phase_q;
          geom_set      = (line_len_q != LINE_W'(H_PIXELS));
          frame_lines_d = frame_lines_q + FRAME_W'(1);
`ifdef CAPTURE_STATS_EN
          last_line_len_d = line_len_q;
`endif
        end
        if (vs_rise) begin
          state_d      = ST_WAIT;
          frame_done_d = 1'b1;
          if (frame_lines_d != FRAME_W'(V_LINES)) begin
            geom_set = 1'b1;
          end
`ifdef CAPTURE_STATS_EN
          frame_cnt_d        = frame_cnt_q + 16'd1;
          last_frame_lines_d = frame_lines_d;
`endif
        end
      end
      default: state_d = ST_SKIP;
    endcase

    if (href_fall) begin
      phase_d = 1'b0;
    end

    err_ovf_d  = ovf_set  | (err_ovf_q  & ~bus.err_clr);
    err_odd_d  = odd_set  | (err_odd_q  & ~bus.err_clr);
    err_geom_d = geom_set | (err_geom_q & ~bus.err_clr);
  end

  assign bus.pix_data    = pix_data_q;
  assign bus.pix_wr      = pix_wr_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err_ovf     = err_ovf_q;
  assign bus.err_odd     = err_odd_q;
  assign bus.err_geom    = err_geom_q;
`ifdef CAPTURE_STATS_EN
  assign bus.frame_cnt        = frame_cnt_q;
  assign bus.last_line_len    = last_line_len_q;
  assign bus.last_frame_lines = last_frame_lines_q;
`endif

endmodule

// File: tb/tb_cam_dvp_capture_module.sv
// Directed bench for cam_dvp_capture_module with SKIP_FRAMES=2, 8 words x 4 lines per frame.
module tb_cam_dvp_capture_module;

  localparam int unsigned H = 8;
  localparam int unsigned V = 4;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  cam_dvp_capture_module_if bus ();

  cam_dvp_capture_module #(
    .SKIP_FRAMES (2),
    .H_PIXELS    (H),
    .V_LINES     (V)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;
  int wr_cnt  = 0;
  int fs_cnt  = 0;
  int fd_cnt  = 0;
  int w0, fs0, fd0;

  // Event counters sampled mid-cycle; each strobe is high for exactly one cycle.
  always @(negedge CLK) begin
    if (bus.pix_wr)      wr_cnt <= wr_cnt + 1;
    if (bus.frame_start) fs_cnt <= fs_cnt + 1;
    if (bus.frame_done)  fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_line(input int nbytes, input int full_at);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge CLK);
      bus.cam_href  = 1'b1;
      bus.cam_data  = 8'(i * 7 + 3);
      bus.fifo_full = (i == full_at);
    end
    @(negedge CLK);
    bus.cam_href  = 1'b0;
    bus.fifo_full = 1'b0;
    bus.cam_data  = 8'h00;
    idle(4);
  endtask

  task automatic vsync_pulse();
    @(negedge CLK);
    bus.cam_vsync = 1'b1;
    idle(4);
    bus.cam_vsync = 1'b0;
    idle(5);
  endtask

  task automatic send_frame(input int nlines);
    for (int l = 0; l < nlines; l++) send_line(16, -1);
    vsync_pulse();
  endtask

  task automatic clear_errors();
    @(negedge CLK);
    bus.err_clr = 1'b1;
    @(negedge CLK);
    bus.err_clr = 1'b0;
    idle(1);
  endtask

  initial begin
    bus.cam_vsync  = 1'b0;
    bus.cam_href   = 1'b0;
    bus.cam_data   = 8'h00;
    bus.capture_en = 1'b1;
    bus.fifo_full  = 1'b0;
    bus.err_clr    = 1'b0;

    // Reset state
    idle(3);
    chk("rst_pix_wr",      32'(bus.pix_wr),      32'd0);
    chk("rst_pix_data",    32'(bus.pix_data),    32'd0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd0);
    chk("rst_frame_done",  32'(bus.frame_done),  32'd0);
    chk("rst_err_ovf",     32'(bus.err_ovf),     32'd0);
    chk("rst_err_odd",     32'(bus.err_odd),     32'd0);
    chk("rst_err_geom",    32'(bus.err_geom),    32'd0);
`ifdef CAPTURE_STATS_EN
    chk("rst_frame_cnt",   32'(bus.frame_cnt),   32'd0);
`endif
    RSTn = 1'b1;
    idle(2);

    // Two skipped frames: no writes, frame_start only once the skip count is reached
    w0 = wr_cnt; fs0 = fs_cnt; fd0 = fd_cnt;
    send_frame(V);
    chk("skip1_fs", 32'(fs_cnt - fs0), 32'd0);
    send_frame(V);
    chk("skip_wr", 32'(wr_cnt - w0),   32'd0);
    chk("skip_fd", 32'(fd_cnt - fd0),  32'd0);
    chk("skip_fs", 32'(fs_cnt - fs0),  32'd1);

    // Frame 3: first line carries F8,1F to check packing latency and alternation
    w0 = wr_cnt; fs0 = fs_cnt; fd0 = fd_cnt;
    @(negedge CLK); bus.cam_href = 1'b1; bus.cam_data = 8'hF8;
    @(negedge CLK); bus.cam_data = 8'h1F;
    @(negedge CLK); chk("lat_edge1_wr", 32'(bus.pix_wr), 32'd0); bus.cam_data = 8'h12;
    @(negedge CLK); chk("lat_edge2_wr", 32'(bus.pix_wr), 32'd1);
                    chk("lat_data", 32'(bus.pix_data), 32'h0000F81F); bus.cam_data = 8'h34;
    @(negedge CLK); chk("alt_gap_wr", 32'(bus.pix_wr), 32'd0);
                    chk("hold_data", 32'(bus.pix_data), 32'h0000F81F); bus.cam_data = 8'h56;
    @(negedge CLK); chk("alt_next_wr", 32'(bus.pix_wr), 32'd1);
                    chk("alt_data", 32'(bus.pix_data), 32'h00001234); bus.cam_data = 8'h78;
    for (int i = 6; i < 16; i++) begin
      @(negedge CLK); bus.cam_data = 8'(i * 7 + 3);
    end
    @(negedge CLK); bus.cam_href = 1'b0; bus.cam_data = 8'h00;
    idle(4);
    send_line(16, -1);
    send_line(16, -1);
    send_line(16, -1);
    chk("f3_wr", 32'(wr_cnt - w0), 32'd32);
    chk("f3_fs", 32'(fs_cnt - fs0), 32'd0);
    vsync_pulse();
    chk("f3_fd", 32'(fd_cnt - fd0), 32'd1);
    chk("f3_err_geom", 32'(bus.err_geom), 32'd0);
    chk("f3_err_odd",  32'(bus.err_odd),  32'd0);
    chk("f3_err_ovf",  32'(bus.err_ovf),  32'd0);

    // Frame 4: fifo_full drops word 5 of the first line
    w0 = wr_cnt;
    send_line(16, 10);
    chk("ovf_wr",       32'(wr_cnt - w0),  32'd7);
    chk("ovf_err_ovf",  32'(bus.err_ovf),  32'd1);
    chk("ovf_err_geom", 32'(bus.err_geom), 32'd0);
    clear_errors();
    chk("ovf_clr", 32'(bus.err_ovf), 32'd0);
    send_line(16, -1);
    send_line(16, -1);
    send_line(16, -1);
    vsync_pulse();
    chk("f4_err_geom", 32'(bus.err_geom), 32'd0);

    // Frame 5: a 17-byte line, then a clean 16-byte line, then a short frame
    w0 = wr_cnt;
    send_line(17, -1);
    chk("odd_wr",      32'(wr_cnt - w0), 32'd8);
    chk("odd_err_odd", 32'(bus.err_odd), 32'd1);
    clear_errors();
    w0 = wr_cnt;
    send_line(16, -1);
    chk("clean_wr",       32'(wr_cnt - w0),  32'd8);
    chk("clean_err_odd",  32'(bus.err_odd),  32'd0);
    chk("clean_err_geom", 32'(bus.err_geom), 32'd0);
    bus.capture_en = 1'b0;
    fs0 = fs_cnt; fd0 = fd_cnt;
    vsync_pulse();
    chk("short_err_geom", 32'(bus.err_geom), 32'd1);
    chk("short_fd", 32'(fd_cnt - fd0), 32'd1);
    chk("dis_fs",   32'(fs_cnt - fs0), 32'd0);
    clear_errors();

    // Frame 6 is not captured; capture_en returns before its closing vsync
    w0 = wr_cnt; fd0 = fd_cnt; fs0 = fs_cnt;
    for (int l = 0; l < 4; l++) send_line(16, -1);
    bus.capture_en = 1'b1;
    vsync_pulse();
    chk("dis_wr", 32'(wr_cnt - w0),  32'd0);
    chk("dis_fd", 32'(fd_cnt - fd0), 32'd0);
    chk("en_fs",  32'(fs_cnt - fs0), 32'd1);

    // Frame 7: capture_en dropped after the first line, frame still completes
    w0 = wr_cnt; fd0 = fd_cnt; fs0 = fs_cnt;
    send_line(16, -1);
    bus.capture_en = 1'b0;
    send_line(16, -1);
    send_line(16, -1);
    send_line(16, -1);
    vsync_pulse();
    chk("mid_dis_wr",   32'(wr_cnt - w0),  32'd32);
    chk("mid_dis_fd",   32'(fd_cnt - fd0), 32'd1);
    chk("mid_dis_fs",   32'(fs_cnt - fs0), 32'd0);
    chk("mid_dis_geom", 32'(bus.err_geom), 32'd0);

    // Frame 8: reset asserted mid-line while a write strobe is high
    bus.capture_en = 1'b1;
    vsync_pulse();
    send_line(16, 10);
    chk("pre_rst_ovf", 32'(bus.err_ovf), 32'd1);
    @(negedge CLK); bus.cam_href = 1'b1; bus.cam_data = 8'hAB;
    @(negedge CLK); bus.cam_data = 8'hCD;
    @(negedge CLK); bus.cam_data = 8'hEF;
    @(negedge CLK);
    chk("pre_rst_wr", 32'(bus.pix_wr), 32'd1);
    RSTn = 1'b0;
    #1;
    chk("mid_rst_pix_wr",   32'(bus.pix_wr),   32'd0);
    chk("mid_rst_pix_data", 32'(bus.pix_data), 32'd0);
    chk("mid_rst_err_ovf",  32'(bus.err_ovf),  32'd0);
    chk("mid_rst_fs",       32'(bus.frame_start), 32'd0);
`ifdef CAPTURE_STATS_EN
    chk("mid_rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
`endif
    bus.cam_href = 1'b0;
    bus.cam_data = 8'h00;
    idle(3);
    RSTn = 1'b1;
    idle(2);

    // After reset: two skipped frames again, then one captured frame
    w0 = wr_cnt;
    send_frame(V);
    send_frame(V);
    chk("rst_skip_wr", 32'(wr_cnt - w0), 32'd0);
    w0 = wr_cnt; fd0 = fd_cnt;
    send_frame(V);
    chk("rst_cap_wr", 32'(wr_cnt - w0),  32'd32);
    chk("rst_cap_fd", 32'(fd_cnt - fd0), 32'd1);
`ifdef CAPTURE_STATS_EN
    chk("stat_frame_cnt",   32'(bus.frame_cnt),        32'd1);
    chk("stat_line_len",    32'(bus.last_line_len),    32'd8);
    chk("stat_frame_lines", 32'(bus.last_frame_lines), 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
